serial_add_ctrl: RTL and testbench

Bit-serial adder/subtractor controller built around one shared full_adder cell.
- Accepts two WIDTH-bit operands on a start pulse.
- Drives the full adder one bit per cycle, LSB first, through a carry flip-flop.
- Returns a registered WIDTH-bit result with carry-out and a done pulse.
- Trades WIDTH cycles of latency for a single adder cell; intended as the arithmetic engine for small sequential datapaths.

---
 rtl/serial_add_ctrl_pkg.sv | 11 +
 rtl/serial_add_ctrl_full_adder.sv | 20 ++
 rtl/serial_add_ctrl.sv | 115 +++++++++++
 tb/tb_serial_add_ctrl.sv | 201 ++++++++++++++++++++
 4 files changed

// File: rtl/serial_add_ctrl_pkg.sv
// Shared types for the bit-serial adder/subtractor controller.
// Contents: FSM state type with fixed encoding (IDLE=0, RUN=1, DONE=2).
package serial_add_ctrl_pkg;

  typedef enum logic [1:0] {
    StIdle = 2'd0,
    StRun  = 2'd1,
    StDone = 2'd2
  } state_e;

endpackage

// File: rtl/serial_add_ctrl_full_adder.sv
// Single-bit full adder cell, purely combinational.
// Ports:
//   A, B, C : addend bits and carry-in
//   S       : sum bit
//   Cy      : carry-out
module full_adder (
  input  logic A,
  input  logic B,
  input  logic C,
  output logic S,
  output logic Cy
);

  logic w_p;

  assign w_p = A ^ B;
  assign S   = w_p ^ C;
  assign Cy  = (A & B) | (C & w_p);

endmodule

// File: rtl/serial_add_ctrl.sv
// Bit-serial adder/subtractor controller. One shared full_adder cell processes the operands
// LSB first, one bit per clock, through a carry flip-flop.
// Ports:
//   clk, rst_n : clock, asynchronous active-low reset
//   start      : operation request, sampled only in IDLE
//   sub        : 0 = a+b+cin, 1 = a-b (cin ignored)
//   a, b, cin  : operands and add-mode carry-in, sampled with start
//   busy       : high in RUN and DONE
//   done       : one-cycle pulse when sum/cout are updated
//   sum, cout  : registered result and final carry (sub mode: 1 = no borrow)
module serial_add_ctrl
  import serial_add_ctrl_pkg::*;
#(
  parameter int unsigned WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             sub,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             cout
);

  localparam int unsigned CntW = $clog2(WIDTH);
  localparam logic [CntW-1:0] CntLast = CntW'(WIDTH - 1);

  state_e           r_state;
  logic [WIDTH-1:0] r_a_sh;
  logic [WIDTH-1:0] r_b_sh;
  logic [WIDTH-1:0] r_res_sh;
  logic [CntW-1:0]  r_cnt;
  logic             r_carry;
  logic             r_busy;
  logic             r_done;
  logic [WIDTH-1:0] r_sum;
  logic             r_cout;

  logic             w_s;
  logic             w_cy;
  logic [WIDTH-1:0] w_res_next;

  full_adder u_fa (
    .A  (r_a_sh[0]),
    .B  (r_b_sh[0]),
    .C  (r_carry),
    .S  (w_s),
    .Cy (w_cy)
  );

  // New sum bit enters at the MSB so that after WIDTH shifts bit 0 sits at the LSB.
  assign w_res_next = {w_s, r_res_sh[WIDTH-1:1]};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state  <= StIdle;
      r_a_sh   <= '0;
      r_b_sh   <= '0;
      r_res_sh <= '0;
      r_cnt    <= '0;
      r_carry  <= 1'b0;
      r_busy   <= 1'b0;
      r_done   <= 1'b0;
      r_sum    <= '0;
      r_cout   <= 1'b0;
    end else begin
      unique case (r_state)
        StIdle: begin
          if (start) begin
            // Subtraction as a + ~b + 1: invert B and force the initial carry.
            r_a_sh  <= a;
            r_b_sh  <= sub ? ~b : b;
            r_carry <= sub ? 1'b1 : cin;
            r_cnt   <= '0;
            r_busy  <= 1'b1;
            r_state <= StRun;
          end
        end
        StRun: begin
          r_res_sh <= w_res_next;
          r_a_sh   <= {1'b0, r_a_sh[WIDTH-1:1]};
          r_b_sh   <= {1'b0, r_b_sh[WIDTH-1:1]};
          r_carry  <= w_cy;
          r_cnt    <= r_cnt + 1'b1;
          if (r_cnt == CntLast) begin
            r_sum   <= w_res_next;
            r_cout  <= w_cy;
            r_done  <= 1'b1;
            r_state <= StDone;
          end
        end
        StDone: begin
          r_done  <= 1'b0;
          r_busy  <= 1'b0;
          r_state <= StIdle;
        end
        default: begin
          r_done  <= 1'b0;
          r_busy  <= 1'b0;
          r_state <= StIdle;
        end
      endcase
    end
  end

  assign busy = r_busy;
  assign done = r_done;
  assign sum  = r_sum;
  assign cout = r_cout;

endmodule

// File: tb/tb_serial_add_ctrl.sv
module tb_serial_add_ctrl;

  localparam int W = 8;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         start = 1'b0;
  logic         sub = 1'b0;
  logic [W-1:0] a = '0;
  logic [W-1:0] b = '0;
  logic         cin = 1'b0;
  logic         busy;
  logic         done;
  logic [W-1:0] sum;
  logic         cout;

  serial_add_ctrl #(.WIDTH(W)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .start (start),
    .sub   (sub),
    .a     (a),
    .b     (b),
    .cin   (cin),
    .busy  (busy),
    .done  (done),
    .sum   (sum),
    .cout  (cout)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;
  logic [W-1:0] prev_sum = '0;
  logic         prev_cout = 1'b0;

  typedef struct {
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         sub;
    logic         cin;
    logic [W-1:0] exp_sum;
    logic         exp_cout;
  } vec_t;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
    end
  endtask

  // Reference: plain (W+1)-bit arithmetic on the values present at the start edge.
  function automatic logic [W:0] model(input logic [W-1:0] ma, input logic [W-1:0] mb,
                                       input logic msub, input logic mcin);
    logic [W:0] r;
    if (msub) r = {1'b0, ma} + {1'b0, ~mb} + (W+1)'(1);
    else      r = {1'b0, ma} + {1'b0, mb} + {{W{1'b0}}, mcin};
    return r;
  endfunction

  // Drives one operation and checks timing, busy profile, hold behaviour and result.
  task automatic run_op(input logic [W-1:0] ta, input logic [W-1:0] tb, input logic tsub,
                        input logic tcin, input bit scramble, input string nm);
    logic [W:0] exp;
    int lat;
    bit busy_ok, hold_ok, done_ok;
    logic [W-1:0] got_sum;
    logic got_cout;
    exp = model(ta, tb, tsub, tcin);
    lat = -1; busy_ok = 1; hold_ok = 1; done_ok = 1;
    got_sum = '0; got_cout = 1'b0;
    @(posedge clk); #1;
    a = ta; b = tb; sub = tsub; cin = tcin; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    for (int k = 0; k <= W + 3; k++) begin
      if (busy !== (k <= W)) busy_ok = 0;
      if (done === 1'b1) begin
        if (lat != -1) done_ok = 0;
        lat = k;
        got_sum = sum; got_cout = cout;
        prev_sum = sum; prev_cout = cout;
      end else if (sum !== prev_sum || cout !== prev_cout) begin
        hold_ok = 0;
      end
      if (scramble && k <= W) begin
        a = W'($urandom); b = W'($urandom);
        sub = 1'($urandom); cin = 1'($urandom); start = 1'($urandom);
      end else begin
        start = 1'b0;
      end
      @(posedge clk); #1;
    end
    chk({nm, " latency"}, 32'(lat), 32'(W));
    chk({nm, " sum"}, 32'(got_sum), 32'(exp[W-1:0]));
    chk({nm, " cout"}, 32'(got_cout), 32'(exp[W]));
    chk({nm, " busy_profile"}, 32'(busy_ok), 32'd1);
    chk({nm, " single_done"}, 32'(done_ok), 32'd1);
    chk({nm, " hold"}, 32'(hold_ok), 32'd1);
  endtask

  vec_t vecs[7];
  int   n_done;
  bit   hold_ok;

  initial begin
    vecs[0] = '{8'h5A, 8'h3C, 1'b0, 1'b0, 8'h96, 1'b0};
    vecs[1] = '{8'hFF, 8'h01, 1'b0, 1'b0, 8'h00, 1'b1};
    vecs[2] = '{8'hFF, 8'h00, 1'b0, 1'b1, 8'h00, 1'b1};
    vecs[3] = '{8'h10, 8'h01, 1'b1, 1'b1, 8'h0F, 1'b1};
    vecs[4] = '{8'h00, 8'h01, 1'b1, 1'b0, 8'hFF, 1'b0};
    vecs[5] = '{8'h80, 8'h80, 1'b0, 1'b0, 8'h00, 1'b1};
    vecs[6] = '{8'h55, 8'h55, 1'b1, 1'b0, 8'h00, 1'b1};

    // Reset state, checked before any clock edge.
    #1;
    chk("reset busy", 32'(busy), 32'd0);
    chk("reset done", 32'(done), 32'd0);
    chk("reset sum", 32'(sum), 32'd0);
    chk("reset cout", 32'(cout), 32'd0);
    #13 rst_n = 1'b1;

    // Directed table: constants computed by hand.
    foreach (vecs[i]) begin
      logic [W:0] m;
      m = model(vecs[i].a, vecs[i].b, vecs[i].sub, vecs[i].cin);
      chk($sformatf("table%0d model", i), 32'(m), 32'({vecs[i].exp_cout, vecs[i].exp_sum}));
      run_op(vecs[i].a, vecs[i].b, vecs[i].sub, vecs[i].cin, 1'b0, $sformatf("table%0d", i));
    end

    // Start while busy (RUN and DONE) is ignored; start right after done is accepted.
    @(posedge clk); #1;
    a = 8'h11; b = 8'h22; sub = 1'b0; cin = 1'b0; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0; n_done = 0;
    for (int k = 0; k <= W; k++) begin
      if (done === 1'b1) begin
        n_done++;
        chk("busy_start sum", 32'(sum), 32'h33);
      end
      if (k == 2 || k == W) begin
        start = 1'b1; a = 8'hAA; b = 8'h55;
      end else begin
        start = 1'b0;
      end
      @(posedge clk); #1;
    end
    chk("busy_start done_count", 32'(n_done), 32'd1);
    chk("busy_start idle", 32'(busy), 32'd0);
    start = 1'b1; a = 8'hAA; b = 8'h55;
    @(posedge clk); #1;
    start = 1'b0;
    chk("restart accepted", 32'(busy), 32'd1);
    n_done = 0;
    for (int k = 0; k < 3 * W && n_done == 0; k++) begin
      @(posedge clk); #1;
      if (done === 1'b1) n_done++;
    end
    chk("restart done", 32'(n_done), 32'd1);
    chk("restart sum", 32'(sum), 32'hFF);
    chk("restart cout", 32'(cout), 32'd0);
    prev_sum = sum; prev_cout = cout;

    // Asynchronous reset in the middle of RUN.
    @(posedge clk); #1;
    a = 8'h5A; b = 8'h3C; sub = 1'b0; cin = 1'b0; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (4) @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("midrst busy", 32'(busy), 32'd0);
    chk("midrst done", 32'(done), 32'd0);
    chk("midrst sum", 32'(sum), 32'd0);
    chk("midrst cout", 32'(cout), 32'd0);
    @(posedge clk); #3 rst_n = 1'b1;
    n_done = 0; hold_ok = 1;
    for (int k = 0; k < W + 4; k++) begin
      @(posedge clk); #1;
      if (done === 1'b1) n_done++;
      if (busy !== 1'b0 || sum !== '0 || cout !== 1'b0) hold_ok = 0;
    end
    chk("midrst no_done", 32'(n_done), 32'd0);
    chk("midrst quiet", 32'(hold_ok), 32'd1);
    prev_sum = '0; prev_cout = 1'b0;
    run_op(8'hC3, 8'h4D, 1'b0, 1'b1, 1'b0, "post_reset");

    // Random operations with inputs disturbed throughout RUN/DONE.
    for (int i = 0; i < 500; i++) begin
      run_op(W'($urandom), W'($urandom), 1'($urandom), 1'($urandom), 1'b1,
             $sformatf("rand%0d", i));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
